// File: rtl/keypad_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : keypad_uart_tx
// Purpose  : Accepts a keypad key byte with a one-cycle ack and sends it as
//            an 8N1 UART frame, LSB first.
// Revision : 1.0 - initial release
// ============================================================================
module keypad_uart_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int CNT_W        = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_tx_key_send,
    input  logic [7:0] i_key,
    output logic       o_tx_keypad_proc,
    output logic       o_tx,
    output logic       o_busy,
    output logic       o_tx_done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] c_last_cnt = CNT_W'(CLKS_PER_BIT - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_idx;
    logic [7:0]       r_shift;
    logic             w_bit_end;

    assign w_bit_end = (r_cnt == c_last_cnt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= S_IDLE;
            r_cnt            <= '0;
            r_idx            <= '0;
            r_shift          <= '0;
            o_tx             <= 1'b1;
            o_busy           <= 1'b0;
            o_tx_keypad_proc <= 1'b0;
            o_tx_done        <= 1'b0;
        end else begin
            o_tx_keypad_proc <= 1'b0;
            o_tx_done        <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_tx_key_send) begin
                        r_shift          <= i_key;
                        r_cnt            <= '0;
                        r_idx            <= '0;
                        o_tx             <= 1'b0;
                        o_busy           <= 1'b1;
                        o_tx_keypad_proc <= 1'b1;
                        r_state          <= S_START;
                    end
                end
                S_START: begin
                    if (w_bit_end) begin
                        r_cnt   <= '0;
                        r_idx   <= '0;
                        o_tx    <= r_shift[0];
                        r_state <= S_DATA;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        r_cnt <= '0;
                        if (r_idx == 3'd7) begin
                            o_tx    <= 1'b1;
                            r_state <= S_STOP;
                        end else begin
                            // r_shift[0] is the bit on the line; [1] is next
                            r_idx   <= r_idx + 3'd1;
                            o_tx    <= r_shift[1];
                            r_shift <= {1'b0, r_shift[7:1]};
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_STOP: begin
                    if (w_bit_end) begin
                        r_cnt     <= '0;
                        o_busy    <= 1'b0;
                        o_tx_done <= 1'b1;
                        r_state   <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    o_tx    <= 1'b1;
                    o_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_keypad_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_keypad_uart_tx
// Purpose  : Directed self-checking bench for keypad_uart_tx (CLKS_PER_BIT=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_keypad_uart_tx;

    logic       clk;
    logic       rst_n;
    logic       i_tx_key_send;
    logic [7:0] i_key;
    logic       o_tx_keypad_proc;
    logic       o_tx;
    logic       o_busy;
    logic       o_tx_done;

    int n_checks = 0;
    int n_errors = 0;
    int ack_cnt  = 0;
    int done_cnt = 0;
    int both_cnt = 0;

    keypad_uart_tx #(
        .CLKS_PER_BIT(4),
        .CNT_W       (16)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_tx_key_send   (i_tx_key_send),
        .i_key           (i_key),
        .o_tx_keypad_proc(o_tx_keypad_proc),
        .o_tx            (o_tx),
        .o_busy          (o_busy),
        .o_tx_done       (o_tx_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters: values seen during the cycle that just ended
    always @(posedge clk) begin
        if (o_tx_keypad_proc) ack_cnt++;
        if (o_tx_done) done_cnt++;
        if (o_tx_keypad_proc && o_tx_done) both_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // exp_line: bit0 = start, bits1..8 = data LSB first, bit9 = stop
    task automatic run_frame(input logic [7:0] key, input logic [9:0] exp_line,
                             input int hold, input int mid_at,
                             input logic mid_req, input logic [7:0] mid_key);
        i_tx_key_send = 1'b1;
        i_key         = key;
        @(posedge clk);
        @(negedge clk);
        check("ack_pulse", 32'(o_tx_keypad_proc), 32'd1);
        for (int c = 0; c < 40; c++) begin
            check("line_bit", 32'(o_tx), 32'(exp_line[c/4]));
            check("busy_in_frame", 32'(o_busy), 32'd1);
            if (c > 0) check("no_extra_ack", 32'(o_tx_keypad_proc), 32'd0);
            if (c == hold) i_tx_key_send = 1'b0;
            if (c == mid_at) begin
                i_tx_key_send = mid_req;
                i_key         = mid_key;
            end
            @(negedge clk);
        end
        check("done_pulse", 32'(o_tx_done), 32'd1);
        check("busy_clear", 32'(o_busy), 32'd0);
        check("idle_line", 32'(o_tx), 32'd1);
        check("ack_not_with_done", 32'(o_tx_keypad_proc), 32'd0);
    endtask

    initial begin
        rst_n         = 1'b0;
        i_tx_key_send = 1'b0;
        i_key         = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_tx", 32'(o_tx), 32'd1);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_ack", 32'(o_tx_keypad_proc), 32'd0);
        check("rst_done", 32'(o_tx_done), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 'w' = 8'h77, source drops the request right after the ack
        run_frame(8'h77, 10'b1011101110, 0, -1, 1'b0, 8'h00);
        @(negedge clk);
        check("done_one_cycle", 32'(o_tx_done), 32'd0);

        // 'a' = 8'h61, request held 3 cycles past the ack
        run_frame(8'h61, 10'b1011000010, 3, -1, 1'b0, 8'h00);
        repeat (2) @(negedge clk);

        // 's' = 8'h73 with 'd' requested mid-frame, then 8'h64 back-to-back
        run_frame(8'h73, 10'b1011100110, 0, 20, 1'b1, 8'h64);
        run_frame(8'h64, 10'b1011001000, 0, -1, 1'b0, 8'h00);
        repeat (2) @(negedge clk);

        // i_key switched to 8'hFF during data bit 2 must not alter 8'h77
        run_frame(8'h77, 10'b1011101110, 0, 14, 1'b0, 8'hFF);
        repeat (2) @(negedge clk);
        check("ack_count_a", 32'(ack_cnt), 32'd5);
        check("done_count_a", 32'(done_cnt), 32'd5);

        // Asynchronous reset during data bit 3 of 8'h77 (bit 3 = 0)
        i_tx_key_send = 1'b1;
        i_key         = 8'h77;
        @(posedge clk);
        @(negedge clk);
        i_tx_key_send = 1'b0;
        repeat (17) @(negedge clk);
        check("pre_rst_bit3", 32'(o_tx), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_tx", 32'(o_tx), 32'd1);
        check("async_rst_busy", 32'(o_busy), 32'd0);
        @(negedge clk);
        @(negedge clk);
        check("held_rst_tx", 32'(o_tx), 32'd1);
        rst_n = 1'b1;
        run_frame(8'h64, 10'b1011001000, 0, -1, 1'b0, 8'h00);

        // Idle stability
        i_tx_key_send = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            check("idle_tx", 32'(o_tx), 32'd1);
        end
        @(negedge clk);
        check("ack_count_final", 32'(ack_cnt), 32'd7);
        check("done_count_final", 32'(done_cnt), 32'd6);
        check("ack_done_overlap", 32'(both_cnt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
